// File: rtl/nes_pkg.sv
// Shared NES CPU-bus constants and types used by the OAM DMA engine.
package nes_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 8;

  localparam logic [ADDR_W-1:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [ADDR_W-1:0] OAMDATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    GET   = 3'd3,
    PUT   = 3'd4
  } dma_state_t;

  // One bus-cycle request as seen by the bus decoder.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] data;
  } bus_req_t;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: on a CPU write to $4014 halts the CPU and copies page $XX00-$XXFF
// to OAMDATA through the CPU bus, owning addr/rw/wdata while the copy runs.
module oam_dma
  import nes_pkg::ADDR_W, nes_pkg::DATA_W, nes_pkg::IDX_W, nes_pkg::dma_state_t,
         nes_pkg::bus_req_t, nes_pkg::IDLE, nes_pkg::HALT, nes_pkg::ALIGN,
         nes_pkg::GET, nes_pkg::PUT;
#(
  parameter logic [ADDR_W-1:0] OAMDMA_ADDR  = nes_pkg::OAMDMA_ADDR,
  parameter logic [ADDR_W-1:0] OAMDATA_ADDR = nes_pkg::OAMDATA_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rw,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic [DATA_W-1:0] bus_data_i,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_data_o,
  output logic              cpu_halt,
  output logic              dma_active
);

  dma_state_t       state_q, state_d;
  logic [IDX_W-1:0] page_q, page_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             odd_q;
  logic             trigger;
  bus_req_t         req;

  assign trigger = !cpu_rw && (cpu_addr == OAMDMA_ADDR);

  // State, transfer pointer and the free-running cycle parity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      page_q  <= '0;
      idx_q   <= '0;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      odd_q   <= ~odd_q;
    end
  end

  // Next-state logic and bus ownership mux.
  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    idx_d      = idx_q;
    req.addr   = cpu_addr;
    req.rw     = cpu_rw;
    req.data   = cpu_data_i;
    cpu_halt   = 1'b0;
    dma_active = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          page_d  = cpu_data_i;
          idx_d   = '0;
          state_d = HALT;
        end
      end
      HALT: begin
        // Dummy read cycle; the ALIGN slot keeps GET/PUT on a fixed parity.
        req.rw   = 1'b1;
        cpu_halt = 1'b1;
        state_d  = odd_q ? GET : ALIGN;
      end
      ALIGN: begin
        req.rw   = 1'b1;
        cpu_halt = 1'b1;
        state_d  = GET;
      end
      GET: begin
        req.addr = {page_q, idx_q};
        req.rw   = 1'b1;
        cpu_halt = 1'b1;
        state_d  = PUT;
      end
      PUT: begin
        // Read data from the preceding GET arrives this cycle; forward it unregistered.
        req.addr = OAMDATA_ADDR;
        req.rw   = 1'b0;
        req.data = bus_data_i;
        cpu_halt = 1'b1;
        if (idx_q == IDX_W'(8'hFF)) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = GET;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    dma_active = cpu_halt;
  end

  assign bus_addr   = req.addr;
  assign bus_rw     = req.rw;
  assign bus_data_o = req.data;

endmodule
